hz_scan_ctrl: RTL and testbench
===============================

HZ_SCAN_CTRL -- requirements
Module: hz_scan_ctrl

Interface
REQ-001 SHALL have parameter ROW_DWELL, 5000, clock cycles each row is lit (min 2).
REQ-002 SHALL have parameter FRAMES_PER_STEP, 50, full 16-row frames per display step (min 1).
REQ-003 SHALL have parameter NUM_CHARS, 3, glyphs in font ROM, 32 bytes each (1..4).
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1, scan enable.
REQ-007 SHALL have port rom_addr, output, 7, font ROM byte address.
REQ-008 SHALL have port rom_dout, input, 8, font ROM data, valid one cycle after rom_addr (registered ROM).
REQ-009 SHALL have port row_sel, output, 16, one-hot active-high row drive; bit 0 = top row.
REQ-010 SHALL have port col_data, output, 16, active-high column drive; bit 15 = leftmost pixel.
REQ-011 SHALL have port char_idx, output, 2, glyph currently at the left edge.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse at end of row 15 HOLD.

Function
REQ-013 SHALL implement FSM IDLE -> FETCH -> HOLD -> FETCH ...; any state -> IDLE the cycle after en=0.
REQ-014 SHALL, in IDLE with en=1, go to FETCH for row 0 next cycle.
REQ-015 SHALL address glyph bytes as char*32 + row*2 + b; b=0 is left half (col_data[15:8]), byte bit 7 = leftmost pixel.
REQ-016 SHALL, in FETCH, issue K consecutive addresses (one per cycle) and capture each byte the following cycle; FETCH lasts K+1 cycles.
REQ-017 SHALL hold row_sel = 0 throughout FETCH and IDLE (blanking, no ghosting).
REQ-018 SHALL update col_data and row_sel together on the first HOLD cycle and keep both stable for exactly ROW_DWELL cycles.
REQ-019 SHALL advance row 0..15, wrapping 15 -> 0; frame_done pulses on the last HOLD cycle of row 15.
REQ-020 SHALL count frames; after FRAMES_PER_STEP frames apply one display step and clear the count.
REQ-021 SHALL wrap char_idx NUM_CHARS-1 -> 0; "next glyph" of the last glyph is glyph 0.
REQ-022 SHALL retain char_idx, step offset and frame count across en=0; row restarts at 0.
REQ-023 SHALL drive rom_addr = 0 when not in FETCH.

Reset
REQ-024 SHALL, on rst_n=0, asynchronously force state IDLE, row_sel=0, col_data=0, rom_addr=0, char_idx=0, frame_done=0, row/frame/dwell counters and offset to 0.
REQ-025 SHALL leave IDLE no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL use macro HZ_SCROLL_EN to compile pixel scrolling in or out.
REQ-027 SHALL, with HZ_SCROLL_EN defined, use K=4 (current then next glyph row), display top 16 bits of {cur,next} << offset; each step increments offset 0..15; 15 -> 0 advances char_idx.
REQ-028 SHALL, without HZ_SCROLL_EN, use K=2, display cur row directly, each step advance char_idx; no offset register exists.

Structure
REQ-029 SHALL place state enum, ROWS=16, CHAR_BYTES=32, ROW_BYTES=2 in package hz_scan_pkg.
REQ-030 SHALL use one sub-module hz_row_assembler: byte capture plus (when scrolling) 32-bit shift/select to 16-bit col_data.

Verification (ROW_DWELL=4, FRAMES_PER_STEP=2, NUM_CHARS=3, standard 3-glyph ROM model)
REQ-031 SHALL check: reset asserted mid-HOLD -> all outputs 0 same cycle; after release and en=1, row 0 char 0 shows col_data=16'h1000, row_sel=16'h0001.
REQ-032 SHALL check (no scroll): row 1 col_data=16'h11F8; row period = 4+3 cycles; frame_done once per 112 cycles.
REQ-033 SHALL check (no scroll): after 2 frames char_idx=1, row 0 col_data=16'h0040; after 4 more frames wraps to char_idx=0 via char 2 (row 0 = 16'h1FE0).
REQ-034 SHALL check (HZ_SCROLL_EN): offset 4, char 0, row 3 -> col_data=16'h0201; row period 4+5 cycles.
REQ-035 SHALL check: en dropped in second FETCH cycle -> IDLE next cycle, row_sel=0, char_idx unchanged; en re-raised restarts at row 0.

Source files
------------

// File: rtl/hz_scan_pkg.sv
// Shared types and geometry for the scanned 16x16 glyph display.
// Build option: define HZ_SCROLL_EN to compile in pixel scrolling.
package hz_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int ROWS       = 16;
    localparam int CHAR_BYTES = 32;
    localparam int ROW_BYTES  = 2;

`ifdef HZ_SCROLL_EN
    // current glyph row then next glyph row
    localparam int FETCH_BYTES = 4;
`else
    localparam int FETCH_BYTES = 2;
`endif

    // Byte address of one half of one glyph row in the font ROM
    function automatic logic [6:0] glyph_addr(input logic [1:0] ch,
                                              input logic [3:0] row,
                                              input logic       b);
        return 7'(int'(ch) * CHAR_BYTES + int'(row) * ROW_BYTES + int'(b));
    endfunction

endpackage

// File: rtl/hz_row_assembler.sv
// Collects the font bytes of one row and forms the 16-bit column word.
// Build option: HZ_SCROLL_EN selects a 32-bit window shifted by offset.
module hz_row_assembler
    import hz_scan_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cap,
    input  logic        load,
`ifdef HZ_SCROLL_EN
    input  logic [3:0]  offset,
`endif
    input  logic [7:0]  rom_dout,
    output logic [15:0] col_data
);

    logic [15:0] col_next;

`ifdef HZ_SCROLL_EN
    logic [23:0] bytes_q;
    logic [31:0] word;
    logic [31:0] shifted;

    // last byte is taken straight off the ROM bus on the load cycle
    assign word     = {bytes_q, rom_dout};
    assign shifted  = word << offset;
    assign col_next = shifted[31:16];

    // shift in each fetched byte, oldest ends up most significant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   bytes_q <= '0;
        else if (cap) bytes_q <= {bytes_q[15:0], rom_dout};
    end
`else
    logic [7:0] bytes_q;

    assign col_next = {bytes_q, rom_dout};

    // hold the left-half byte until the right half arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   bytes_q <= '0;
        else if (cap) bytes_q <= rom_dout;
    end
`endif

    // column register changes only when a new row is lit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    col_data <= '0;
        else if (load) col_data <= col_next;
    end

endmodule

// File: rtl/hz_scan_ctrl.sv
// Row-scan controller for a 16x16 LED glyph display fed by a font ROM.
// Build option: HZ_SCROLL_EN adds pixel scrolling between glyphs.
module hz_scan_ctrl
    import hz_scan_pkg::*;
#(
    parameter int ROW_DWELL       = 5000,
    parameter int FRAMES_PER_STEP = 50,
    parameter int NUM_CHARS       = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [6:0]  rom_addr,
    input  logic [7:0]  rom_dout,
    output logic [15:0] row_sel,
    output logic [15:0] col_data,
    output logic [1:0]  char_idx,
    output logic        frame_done
);

    localparam int DW_W = $clog2(ROW_DWELL);
    localparam int FC_W = $clog2(FRAMES_PER_STEP + 1);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(ROW_DWELL - 1);
    localparam logic [DW_W-1:0] DW_PRE  = DW_W'(ROW_DWELL - 2);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_STEP - 1);
    localparam logic [2:0]      F_LAST  = 3'(FETCH_BYTES);
    localparam logic [1:0]      CH_LAST = 2'(NUM_CHARS - 1);
    localparam logic [3:0]      ROW_LAST = 4'(ROWS - 1);

    state_t            state, state_d;
    logic [2:0]        fcnt;
    logic [DW_W-1:0]   dwell;
    logic [3:0]        row;
    logic [FC_W-1:0]   frame_cnt;
    logic              cap, load, hold_end, frame_end;
    logic [1:0]        next_char, fetch_char;

    assign next_char = (char_idx == CH_LAST) ? 2'd0 : char_idx + 2'd1;
    assign frame_end = hold_end && (row == ROW_LAST);

`ifdef HZ_SCROLL_EN
    logic [3:0] offset;
    // bytes 2 and 3 of a fetch come from the following glyph
    assign fetch_char = fcnt[1] ? next_char : char_idx;
`else
    assign fetch_char = char_idx;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    // next state, ROM address and datapath strobes; en low overrides all
    always_comb begin
        state_d  = state;
        rom_addr = '0;
        cap      = 1'b0;
        load     = 1'b0;
        hold_end = 1'b0;
        case (state)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (fcnt != F_LAST) rom_addr = glyph_addr(fetch_char, row, fcnt[0]);
                // byte fcnt-1 is on the bus; the final one goes straight to load
                if (fcnt != 3'd0 && fcnt != F_LAST) cap = 1'b1;
                if (fcnt == F_LAST) begin
                    load    = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (dwell == DW_LAST) begin
                    hold_end = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!en) begin
            state_d  = ST_IDLE;
            cap      = 1'b0;
            load     = 1'b0;
            hold_end = 1'b0;
        end
    end

    // fetch/dwell sequencing and row counter; idle restarts at row 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt  <= '0;
            dwell <= '0;
            row   <= '0;
        end else begin
            fcnt  <= (state == ST_FETCH && state_d == ST_FETCH) ? fcnt + 3'd1 : 3'd0;
            dwell <= (state == ST_HOLD && state_d == ST_HOLD) ? dwell + DW_W'(1) : '0;
            if (state_d == ST_IDLE) row <= '0;
            else if (hold_end)      row <= row + 4'd1;
        end
    end

    // row drive lights with the new columns and blanks outside HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_sel    <= '0;
            frame_done <= 1'b0;
        end else begin
            if (load)                    row_sel <= 16'd1 << row;
            else if (state_d != ST_HOLD) row_sel <= '0;
            // registered one cycle early so it lines up with the last HOLD cycle
            frame_done <= (state == ST_HOLD) && en && (row == ROW_LAST) && (dwell == DW_PRE);
        end
    end

`ifdef HZ_SCROLL_EN
    // frame counting; each step slides one pixel, a full glyph moves char_idx
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            offset    <= '0;
            char_idx  <= '0;
        end else if (frame_end) begin
            if (frame_cnt == FC_LAST) begin
                frame_cnt <= '0;
                if (offset == 4'd15) begin
                    offset   <= '0;
                    char_idx <= next_char;
                end else begin
                    offset <= offset + 4'd1;
                end
            end else begin
                frame_cnt <= frame_cnt + FC_W'(1);
            end
        end
    end
`else
    // frame counting; each step shows the next glyph
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            char_idx  <= '0;
        end else if (frame_end) begin
            if (frame_cnt == FC_LAST) begin
                frame_cnt <= '0;
                char_idx  <= next_char;
            end else begin
                frame_cnt <= frame_cnt + FC_W'(1);
            end
        end
    end
`endif

    hz_row_assembler u_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .cap      (cap),
        .load     (load),
`ifdef HZ_SCROLL_EN
        .offset   (offset),
`endif
        .rom_dout (rom_dout),
        .col_data (col_data)
    );

endmodule

// File: tb/tb_hz_scan_ctrl.sv
// Self-checking bench for hz_scan_ctrl with a small registered font ROM.
// Build option: HZ_SCROLL_EN must match the RTL build.
module tb_hz_scan_ctrl;

    localparam int RD  = 4;
    localparam int FPS = 2;
    localparam int NC  = 3;
`ifdef HZ_SCROLL_EN
    localparam int K = 4;
    localparam int EXP_P = 9;
    localparam int EXP_FRAME = 144;
    localparam logic [1:0] EXP_C2 = 2'd0;
    localparam logic [6:0] EXP_A  = 7'd3;
`else
    localparam int K = 2;
    localparam int EXP_P = 7;
    localparam int EXP_FRAME = 112;
    localparam logic [1:0] EXP_C2 = 2'd1;
    localparam logic [6:0] EXP_A  = 7'd35;
`endif
    localparam int P = RD + K + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [6:0]  rom_addr;
    logic [7:0]  rom_dout;
    logic [15:0] row_sel, col_data;
    logic [1:0]  char_idx;
    logic        frame_done;

    logic [7:0]  rom [0:127];
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    hz_scan_ctrl #(.ROW_DWELL(RD), .FRAMES_PER_STEP(FPS), .NUM_CHARS(NC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .row_sel(row_sel), .col_data(col_data), .char_idx(char_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_dout <= rom[rom_addr];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // ---------------- model: everything follows from cycles since enable ----------------
    int m_t = 0;
    bit m_run = 1'b0;
    int m_base = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 1'b0; m_t <= 0; m_base <= 0;
        end else if (!en) begin
            if (m_run) m_base <= m_base + m_t / (16 * P);
            m_run <= 1'b0; m_t <= 0;
        end else if (!m_run) begin
            m_run <= 1'b1; m_t <= 0;
        end else begin
            m_t <= m_t + 1;
        end
    end

    function automatic void model_out(output logic [15:0] rs, output logic [15:0] cd,
                                      output logic [6:0] ra, output logic [1:0] ci,
                                      output logic fd, output bit hold);
        int frames, steps, off, c, cn, row, w, g;
        logic [15:0] cur, nxt;
        logic [31:0] word;
        frames = m_base + (m_run ? m_t / (16 * P) : 0);
        steps  = frames / FPS;
`ifdef HZ_SCROLL_EN
        off = steps % 16;
        c   = (steps / 16) % NC;
`else
        off = 0;
        c   = steps % NC;
`endif
        cn = (c + 1) % NC;
        ci = 2'(c);
        rs = '0; cd = '0; ra = '0; fd = 1'b0; hold = 1'b0;
        if (m_run) begin
            row  = (m_t / P) % 16;
            w    = m_t % P;
            hold = (w >= K + 1);
            if (hold) rs = 16'd1 << row;
            fd = hold && row == 15 && w == P - 1;
            if (w < K) begin
                g  = (w >= 2) ? cn : c;
                ra = 7'(g * 32 + row * 2 + (w % 2));
            end
            cur  = {rom[c * 32 + row * 2], rom[c * 32 + row * 2 + 1]};
            nxt  = {rom[cn * 32 + row * 2], rom[cn * 32 + row * 2 + 1]};
            word = {cur, nxt} << off;
`ifdef HZ_SCROLL_EN
            cd = word[31:16];
`else
            cd = cur;
`endif
        end
    endfunction

    // cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        logic [15:0] e_rs, e_cd;
        logic [6:0]  e_ra;
        logic [1:0]  e_ci;
        logic        e_fd;
        bit          e_hold;
        model_out(e_rs, e_cd, e_ra, e_ci, e_fd, e_hold);
        chk("row_sel", 32'(row_sel), 32'(e_rs));
        chk("rom_addr", 32'(rom_addr), 32'(e_ra));
        chk("char_idx", 32'(char_idx), 32'(e_ci));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        if (e_hold || !rst_n) chk("col_data", 32'(col_data), 32'(e_cd));
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_rs(input logic [15:0] v, input int maxc, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            if (row_sel == v) ok = 1'b1;
        end
        if (!ok) timeout(name);
    endtask

    task automatic wait_rs_nz(input int maxc, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            if (row_sel != 16'd0) ok = 1'b1;
        end
        if (!ok) timeout(name);
    endtask

    task automatic wait_frames(input int n, input string name);
        int seen = 0;
        for (int i = 0; i < n * 200 && seen < n; i++) begin
            @(negedge clk);
            if (frame_done) seen++;
        end
        if (seen < n) timeout(name);
    endtask

    initial begin
        int c0, c1;
        for (int i = 0; i < 128; i++) rom[i] = 8'((i * 37 + 11) % 256);
        rom[0]  = 8'h10; rom[1]  = 8'h00;   // char 0 row 0
        rom[2]  = 8'h11; rom[3]  = 8'hF8;   // char 0 row 1
        rom[6]  = 8'h10; rom[7]  = 8'h20;   // char 0 row 3
        rom[32] = 8'h00; rom[33] = 8'h40;   // char 1 row 0
        rom[38] = 8'h1F; rom[39] = 8'hF0;   // char 1 row 3
        rom[64] = 8'h1F; rom[65] = 8'hE0;   // char 2 row 0

        repeat (3) @(negedge clk);
        chk("rst_row_sel", 32'(row_sel), 32'h0);
        chk("rst_col_data", 32'(col_data), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_char_idx", 32'(char_idx), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        wait_rs(16'h0001, 50, "first_row0");
        c0 = cyc;
        chk("row0_col", 32'(col_data), 32'h1000);
        wait_rs(16'h0002, 50, "first_row1");
        c1 = cyc;
        chk("row1_col", 32'(col_data), 32'h11F8);
        chk("row_period", 32'(c1 - c0), 32'(EXP_P));

        wait_frames(1, "frame1");
        c0 = cyc;
        wait_frames(1, "frame2");
        c1 = cyc;
        chk("frame_period", 32'(c1 - c0), 32'(EXP_FRAME));

        wait_rs(16'h0001, 50, "step1_row0");
        chk("step1_char", 32'(char_idx), 32'(EXP_C2));
`ifdef HZ_SCROLL_EN
        chk("step1_col", 32'(col_data), 32'h2000);
`else
        chk("step1_col", 32'(col_data), 32'h0040);
`endif

        // drop en in the second FETCH cycle of row 1
        wait_rs(16'h0000, 50, "row0_end");
        @(negedge clk);
        chk("fetch1_addr", 32'(rom_addr), 32'(EXP_A));
        en = 1'b0;
        @(negedge clk);
        chk("drop_row_sel", 32'(row_sel), 32'h0);
        chk("drop_rom_addr", 32'(rom_addr), 32'h0);
        chk("drop_char", 32'(char_idx), 32'(EXP_C2));
        repeat (3) @(negedge clk);
        en = 1'b1;
        wait_rs_nz(50, "restart");
        chk("restart_row0", 32'(row_sel), 32'h0001);

`ifdef HZ_SCROLL_EN
        wait_frames(6, "frames_to_8");
        wait_rs(16'h0008, 50, "scroll_row3");
        chk("scroll_char", 32'(char_idx), 32'h0);
        chk("scroll_col", 32'(col_data), 32'h0201);
`else
        wait_frames(2, "frames_to_4");
        wait_rs(16'h0001, 50, "char2_row0");
        chk("char2_idx", 32'(char_idx), 32'h2);
        chk("char2_col", 32'(col_data), 32'h1FE0);
        wait_frames(2, "frames_to_6");
        wait_rs(16'h0001, 50, "wrap_row0");
        chk("wrap_idx", 32'(char_idx), 32'h0);
        chk("wrap_col", 32'(col_data), 32'h1000);
`endif

        // asynchronous reset in the middle of a HOLD
        wait_rs_nz(50, "hold_before_reset");
        #2 rst_n = 1'b0;
        #1;
        chk("async_row_sel", 32'(row_sel), 32'h0);
        chk("async_col_data", 32'(col_data), 32'h0);
        chk("async_rom_addr", 32'(rom_addr), 32'h0);
        chk("async_char_idx", 32'(char_idx), 32'h0);
        chk("async_frame_done", 32'(frame_done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_rs_nz(50, "after_reset");
        chk("post_rst_row_sel", 32'(row_sel), 32'h0001);
        chk("post_rst_col", 32'(col_data), 32'h1000);
        chk("post_rst_char", 32'(char_idx), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
